// File: rtl/eth_tx_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_ring_buffer
// Description : Multi-slot Ethernet TX frame ring between the CPU packet write
//               port and the MAC AXI-Stream TX port. The CPU fills slot head
//               while the drain engine streams committed frames from slot tail.
//               Optional feature macro: ETH_TX_PAD_EN (pad short frames to 60B).
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_ring_buffer #(
    parameter int eth_mtu_p            = 2048,
    parameter int data_width_p         = 32,
    parameter int slots_p              = 4,
    localparam int addr_width_lp        = $clog2(eth_mtu_p),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int size_width_lp        = $clog2((((data_width_p / 8) == 1) ? 1 : $clog2(data_width_p / 8)) + 1),
    localparam int slot_width_lp        = $clog2(slots_p),
    localparam int count_width_lp       = $clog2(slots_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            packet_send_i,
    output logic                            packet_req_o,
    input  logic                            packet_wsize_valid_i,
    input  logic [packet_size_width_lp-1:0] packet_wsize_i,
    input  logic                            packet_wvalid_i,
    input  logic [addr_width_lp-1:0]        packet_waddr_i,
    input  logic [data_width_p-1:0]         packet_wdata_i,
    input  logic [size_width_lp-1:0]        packet_wdata_size_i,
    output logic [data_width_p-1:0]         tx_axis_tdata_o,
    output logic [data_width_p/8-1:0]       tx_axis_tkeep_o,
    output logic                            tx_axis_tvalid_o,
    output logic                            tx_axis_tlast_o,
    input  logic                            tx_axis_tready_i,
    output logic                            tx_axis_tuser_o,
    output logic [count_width_lp-1:0]       pending_o,
    output logic [15:0]                     send_count_o
);

    localparam int BPB      = data_width_p / 8;
    localparam int LOG2_BPB = (BPB == 1) ? 0 : $clog2(BPB);
    localparam int OFF_W    = (BPB == 1) ? 1 : LOG2_BPB;
    localparam int WORD_W   = addr_width_lp - LOG2_BPB;
    localparam int DEPTH    = slots_p * (eth_mtu_p / BPB);
    localparam int BEAT_W   = WORD_W + 1;
    localparam int ENT_W    = 1 + BPB + data_width_p;
    localparam int PSW      = packet_size_width_lp;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_STREAM  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Frame storage and fill/drain bookkeeping
    logic [data_width_p-1:0]   mem_q [DEPTH];
    logic [data_width_p-1:0]   rdata_q;
    logic [slot_width_lp-1:0]  head_q, tail_q;
    logic [count_width_lp-1:0] pending_q;
    logic [15:0]               send_count_q;
    logic [PSW-1:0]            wsize_q;
    logic [PSW-1:0]            slot_size_q [slots_p];

    // Drain pipeline: read issue -> in-flight -> 2-entry skid -> output register
    state_t                    state_q, state_d;
    logic [BEAT_W-1:0]         rd_beat_q;
    logic                      inflight_q, inflight_last_q;
    logic [BPB-1:0]            inflight_keep_q, inflight_zmask_q;
    logic [ENT_W-1:0]          skid_q [2];
    logic [1:0]                skid_cnt_q;
    logic [data_width_p-1:0]   tdata_q;
    logic [BPB-1:0]            tkeep_q;
    logic                      tvalid_q, tlast_q;

    logic                      w_req, w_commit, w_release, w_we;
    logic [OFF_W-1:0]          w_off;
    logic [slot_width_lp+WORD_W-1:0] w_wword, w_rword;
    logic [data_width_p-1:0]   w_wdata_sh;
    logic [BPB-1:0]            w_wmask;
    logic [PSW-1:0]            w_size, w_eff_size, w_nbeats;
    logic [OFF_W-1:0]          w_rem;
    logic                      w_rd_last, w_more, w_fetch_ok, w_rd_issue;
    logic [BPB-1:0]            w_rd_keep, w_rd_zmask;
    logic [data_width_p-1:0]   w_zbits;
    logic [ENT_W-1:0]          w_rd_entry, w_src;
    logic                      w_hs, w_out_free, w_src_avail, w_load;
    logic [1:0]                w_occ, w_occ_after;

    // Fill-side address decode; LSB-aligned write data is steered to its lane
    assign w_req      = (pending_q < count_width_lp'(slots_p));
    assign w_commit   = packet_send_i && w_req && (wsize_q != '0);
    assign w_release  = (state_q == S_RELEASE);
    assign w_we       = packet_wvalid_i && w_req;
    assign w_off      = packet_waddr_i[OFF_W-1:0] & OFF_W'(BPB - 1);
    assign w_wword    = {head_q, packet_waddr_i[addr_width_lp-1:LOG2_BPB]};
    assign w_wdata_sh = packet_wdata_i << {w_off, 3'b000};

    // Byte-lane write mask: 2^wdata_size bytes starting at the lane offset
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < BPB; b++) begin
            if ((b >= int'(w_off)) && (b < int'(w_off) + (1 << packet_wdata_size_i)))
                w_wmask[b] = 1'b1;
        end
    end

    // Beat geometry of the frame currently being drained from slot tail
    assign w_size = slot_size_q[tail_q];
`ifdef ETH_TX_PAD_EN
    assign w_eff_size = (w_size < PSW'(60)) ? PSW'(60) : w_size;
`else
    assign w_eff_size = w_size;
`endif
    assign w_nbeats  = (w_eff_size + PSW'(BPB - 1)) >> LOG2_BPB;
    assign w_rem     = w_eff_size[OFF_W-1:0] & OFF_W'(BPB - 1);
    assign w_rd_last = ((PSW'(rd_beat_q) + PSW'(1)) == w_nbeats);
    assign w_more    = (PSW'(rd_beat_q) < w_nbeats);
    assign w_rword   = {tail_q, rd_beat_q[WORD_W-1:0]};

    // Per-beat keep and pad-zero masks, attached at read-issue time
    always_comb begin
        w_rd_keep  = '1;
        w_rd_zmask = '1;
        for (int b = 0; b < BPB; b++) begin
            if (w_rd_last && (w_rem != '0) && (b >= int'(w_rem)))
                w_rd_keep[b] = 1'b0;
`ifdef ETH_TX_PAD_EN
            if ((int'(rd_beat_q) * BPB + b) >= int'(w_size))
                w_rd_zmask[b] = 1'b0;
`endif
        end
    end

    // Expand the byte zero-mask of the returning read into a bit mask
    always_comb begin
        w_zbits = '0;
        for (int b = 0; b < BPB; b++)
            w_zbits[b*8 +: 8] = {8{inflight_zmask_q[b]}};
    end

    // Credit: skid + in-flight may never exceed the two skid entries
    assign w_rd_entry  = {inflight_last_q, inflight_keep_q, rdata_q & w_zbits};
    assign w_hs        = tvalid_q && tx_axis_tready_i;
    assign w_out_free  = !tvalid_q || tx_axis_tready_i;
    assign w_src_avail = (skid_cnt_q != 2'd0) || inflight_q;
    assign w_load      = w_out_free && w_src_avail;
    assign w_src       = (skid_cnt_q != 2'd0) ? skid_q[0] : w_rd_entry;
    assign w_occ       = skid_cnt_q + {1'b0, inflight_q};
    assign w_occ_after = w_occ - {1'b0, w_load};
    assign w_fetch_ok  = ((state_q == S_IDLE) && (pending_q != '0)) ||
                         (state_q == S_FETCH) || (state_q == S_STREAM);
    assign w_rd_issue  = w_fetch_ok && w_more && (w_occ_after < 2'd2);

    // Drain FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pending_q != '0) state_d = S_FETCH;
            S_FETCH:   state_d = S_STREAM;
            S_STREAM:  if (w_hs && tlast_q) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Byte-masked write from the fill side; registered read for the drain side
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BPB; b++) begin
            if (w_we && w_wmask[b])
                mem_q[w_wword][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
        if (w_rd_issue)
            rdata_q <= mem_q[w_rword];
    end

    // Ring pointers, pending/sent counters and the latched fill size
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            pending_q    <= '0;
            send_count_q <= '0;
            wsize_q      <= '0;
            for (int s = 0; s < slots_p; s++)
                slot_size_q[s] <= '0;
        end else begin
            if (w_commit) begin
                slot_size_q[head_q] <= wsize_q;
                head_q              <= head_q + 1'b1;
                wsize_q             <= '0;
            end else if (packet_wsize_valid_i && w_req) begin
                wsize_q <= packet_wsize_i;
            end
            if (w_release) begin
                tail_q       <= tail_q + 1'b1;
                send_count_q <= send_count_q + 16'd1;
            end
            case ({w_commit, w_release})
                2'b10:   pending_q <= pending_q + 1'b1;
                2'b01:   pending_q <= pending_q - 1'b1;
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Drain state, read pipeline, skid buffer and AXIS output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            rd_beat_q        <= '0;
            inflight_q       <= 1'b0;
            inflight_last_q  <= 1'b0;
            inflight_keep_q  <= '0;
            inflight_zmask_q <= '0;
            skid_q[0]        <= '0;
            skid_q[1]        <= '0;
            skid_cnt_q       <= 2'd0;
            tdata_q          <= '0;
            tkeep_q          <= '0;
            tvalid_q         <= 1'b0;
            tlast_q          <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= w_rd_issue;
            if (w_rd_issue) begin
                rd_beat_q        <= rd_beat_q + 1'b1;
                inflight_last_q  <= w_rd_last;
                inflight_keep_q  <= w_rd_keep;
                inflight_zmask_q <= w_rd_zmask;
            end else if (w_release) begin
                rd_beat_q <= '0;
            end

            // Older skid entries drain first; returning reads queue behind them
            if (w_load && (skid_cnt_q != 2'd0)) begin
                skid_q[0] <= skid_q[1];
                if (inflight_q) begin
                    if (skid_cnt_q == 2'd1) skid_q[0] <= w_rd_entry;
                    else                    skid_q[1] <= w_rd_entry;
                end else begin
                    skid_cnt_q <= skid_cnt_q - 2'd1;
                end
            end else if (!w_load && inflight_q) begin
                skid_q[skid_cnt_q[0]] <= w_rd_entry;
                skid_cnt_q            <= skid_cnt_q + 2'd1;
            end

            if (w_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= w_src[data_width_p-1:0];
                tkeep_q  <= w_src[data_width_p +: BPB];
                tlast_q  <= w_src[ENT_W-1];
            end else if (w_hs) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign packet_req_o     = w_req;
    assign tx_axis_tdata_o  = tdata_q;
    assign tx_axis_tkeep_o  = tkeep_q;
    assign tx_axis_tvalid_o = tvalid_q;
    assign tx_axis_tlast_o  = tlast_q;
    assign tx_axis_tuser_o  = 1'b0;
    assign pending_o        = pending_q;
    assign send_count_o     = send_count_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_ring_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_ring_buffer
// Description : Scoreboard bench for eth_tx_ring_buffer (32-bit, 4 slots).
//               Stimulus pushes expected beats on commit; a negedge monitor
//               pops and compares every AXIS handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_ring_buffer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        packet_send_i;
    logic        packet_req_o;
    logic        packet_wsize_valid_i;
    logic [11:0] packet_wsize_i;
    logic        packet_wvalid_i;
    logic [10:0] packet_waddr_i;
    logic [31:0] packet_wdata_i;
    logic [1:0]  packet_wdata_size_i;
    logic [31:0] tx_axis_tdata_o;
    logic [3:0]  tx_axis_tkeep_o;
    logic        tx_axis_tvalid_o;
    logic        tx_axis_tlast_o;
    logic        tx_axis_tready_i;
    logic        tx_axis_tuser_o;
    logic [2:0]  pending_o;
    logic [15:0] send_count_o;

    always #5 clk_i = ~clk_i;

    eth_tx_ring_buffer #(.eth_mtu_p(2048), .data_width_p(32), .slots_p(4)) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .packet_send_i        (packet_send_i),
        .packet_req_o         (packet_req_o),
        .packet_wsize_valid_i (packet_wsize_valid_i),
        .packet_wsize_i       (packet_wsize_i),
        .packet_wvalid_i      (packet_wvalid_i),
        .packet_waddr_i       (packet_waddr_i),
        .packet_wdata_i       (packet_wdata_i),
        .packet_wdata_size_i  (packet_wdata_size_i),
        .tx_axis_tdata_o      (tx_axis_tdata_o),
        .tx_axis_tkeep_o      (tx_axis_tkeep_o),
        .tx_axis_tvalid_o     (tx_axis_tvalid_o),
        .tx_axis_tlast_o      (tx_axis_tlast_o),
        .tx_axis_tready_i     (tx_axis_tready_i),
        .tx_axis_tuser_o      (tx_axis_tuser_o),
        .pending_o            (pending_o),
        .send_count_o         (send_count_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  fbytes [0:2050];
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    logic        prev_stall = 1'b0;
    logic [37:0] prev_bus = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: stall stability and scoreboard comparison of every handshake
    always @(negedge clk_i) begin : mon
        beat_t       eb;
        logic [31:0] m;
        if (!reset_i) begin
            if (prev_stall)
                chk("stall_hold",
                    {26'd0, tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tkeep_o, tx_axis_tdata_o},
                    {26'd0, prev_bus});
            if (tx_axis_tvalid_o && tx_axis_tready_i) begin
                beats_seen <= beats_seen + 1;
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{eb.keep[b]}};
                    chk("beat_keep", 64'(tx_axis_tkeep_o), 64'(eb.keep));
                    chk("beat_user_last", {62'd0, tx_axis_tuser_o, tx_axis_tlast_o}, {62'd0, 1'b0, eb.last});
                    chk("beat_data", 64'(tx_axis_tdata_o & m), 64'(eb.data & m));
                end
            end
            prev_stall <= tx_axis_tvalid_o && !tx_axis_tready_i;
            prev_bus   <= {tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tkeep_o, tx_axis_tdata_o};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input logic [1:0] sz);
        packet_wvalid_i     = 1'b1;
        packet_waddr_i      = 11'(addr);
        packet_wdata_i      = data;
        packet_wdata_size_i = sz;
        tick();
        packet_wvalid_i     = 1'b0;
    endtask

    task automatic load_frame(input int size, input int seed);
        for (int i = 0; i < size + 3; i++) fbytes[i] = 8'(seed + i * 13);
        for (int i = 0; i < size; i += 4)
            wr(i, {fbytes[i+3], fbytes[i+2], fbytes[i+1], fbytes[i]}, 2'd2);
    endtask

    task automatic set_size(input int size);
        packet_wsize_valid_i = 1'b1;
        packet_wsize_i       = 12'(size);
        tick();
        packet_wsize_valid_i = 1'b0;
    endtask

    task automatic commit();
        packet_send_i = 1'b1;
        tick();
        packet_send_i = 1'b0;
    endtask

    task automatic push_frame(input int size);
        int    eff;
        int    nb;
        beat_t e;
        eff = size;
`ifdef ETH_TX_PAD_EN
        if (eff < 60) eff = 60;
`endif
        nb = (eff + 3) / 4;
        for (int bt = 0; bt < nb; bt++) begin
            e = '0;
            for (int b = 0; b < 4; b++) begin
                if (bt * 4 + b < eff)  e.keep[b] = 1'b1;
                if (bt * 4 + b < size) e.data[b*8 +: 8] = fbytes[bt * 4 + b];
            end
            e.last = (bt == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int size, input int seed);
        load_frame(size, seed);
        set_size(size);
        commit();
        push_frame(size);
    endtask

    task automatic wait_drain(input int maxcyc, input bit rnd, input string name);
        int n;
        n = 0;
        while (!((exp_q.size() == 0) && (pending_o == 3'd0) && !tx_axis_tvalid_o) && (n < maxcyc)) begin
            if (rnd) tx_axis_tready_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tx_axis_tready_i = 1'b1;
        chk({name, "_drained"}, 64'(n < maxcyc), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int   base;
        int   sc0;
        int   n;
        logic found;

        reset_i              = 1'b1;
        packet_send_i        = 1'b0;
        packet_wsize_valid_i = 1'b0;
        packet_wsize_i       = '0;
        packet_wvalid_i      = 1'b0;
        packet_waddr_i       = '0;
        packet_wdata_i       = '0;
        packet_wdata_size_i  = '0;
        tx_axis_tready_i     = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        chk("rst_tlast",  64'(tx_axis_tlast_o),  64'd0);
        chk("rst_tuser",  64'(tx_axis_tuser_o),  64'd0);
        chk("rst_tkeep",  64'(tx_axis_tkeep_o),  64'd0);
        chk("rst_tdata",  64'(tx_axis_tdata_o),  64'd0);
        chk("rst_pending", 64'(pending_o), 64'd0);
        chk("rst_send_count", 64'(send_count_o), 64'd0);
        chk("rst_req", 64'(packet_req_o), 64'd1);
        reset_i = 1'b0;
        tick();

        // 64-byte frame, free-running MAC
        base = beats_seen;
        send_frame(64, 8'h10);
        wait_drain(200, 1'b0, "f64");
        chk("f64_beats", 64'(beats_seen - base), 64'd16);
        chk("f64_send_count", 64'(send_count_o), 64'd1);
        chk("f64_pending", 64'(pending_o), 64'd0);

        // 61-byte frame: last tkeep 4'h1
        base = beats_seen;
        send_frame(61, 8'h20);
        wait_drain(200, 1'b0, "f61");
        chk("f61_beats", 64'(beats_seen - base), 64'd16);

        // 1-byte frame
        base = beats_seen;
        send_frame(1, 8'h30);
        wait_drain(100, 1'b0, "f1");
        chk("f1_beats", 64'(beats_seen - base), 64'd1);
        chk("f1_send_count", 64'(send_count_o), 64'd3);

        // Commit with latched size 0 is a no-op
        base = beats_seen;
        commit();
        repeat (10) tick();
        chk("f0_pending", 64'(pending_o), 64'd0);
        chk("f0_beats", 64'(beats_seen - base), 64'd0);
        chk("f0_send_count", 64'(send_count_o), 64'd3);

        // Fill all four slots under full backpressure; fifth commit is dropped
        tx_axis_tready_i = 1'b0;
        base = beats_seen;
        sc0  = int'(send_count_o);
        for (int k = 0; k < 4; k++) send_frame(8 + 4 * k, 8'h40 + 16 * k);
        chk("full_pending", 64'(pending_o), 64'd4);
        chk("full_req", 64'(packet_req_o), 64'd0);
        load_frame(16, 8'hE0);
        set_size(16);
        commit();
        chk("full_pending_after5", 64'(pending_o), 64'd4);
        tx_axis_tready_i = 1'b1;
        wait_drain(400, 1'b0, "full");
        chk("full_beats", 64'(beats_seen - base), 64'd14);
        chk("full_send_count", 64'(send_count_o), 64'(sc0 + 4));
        chk("full_req_after", 64'(packet_req_o), 64'd1);

        // 100-byte frame with narrow writes at lane offsets, random backpressure
        base = beats_seen;
        load_frame(100, 8'h77);
        wr(1, 32'hFFFF_FFA5, 2'd0); fbytes[1] = 8'hA5;
        wr(2, 32'hDEAD_C3B4, 2'd1); fbytes[2] = 8'hB4; fbytes[3] = 8'hC3;
        wr(5, 32'h1234_565A, 2'd0); fbytes[5] = 8'h5A;
        wr(6, 32'hBEEF_1E2D, 2'd1); fbytes[6] = 8'h2D; fbytes[7] = 8'h1E;
        set_size(100);
        commit();
        push_frame(100);
        wait_drain(800, 1'b1, "f100");
        chk("f100_beats", 64'(beats_seen - base), 64'd25);

        // Commit landing in the release cycle of the previous frame
        sc0 = int'(send_count_o);
        send_frame(100, 8'h21);
        load_frame(8, 8'h99);
        set_size(8);
        found = 1'b0;
        n = 0;
        while (!found && (n < 300)) begin
            @(negedge clk_i);
            if (tx_axis_tvalid_o && tx_axis_tready_i && tx_axis_tlast_o) found = 1'b1;
            n++;
        end
        chk("rel_last_seen", 64'(found), 64'd1);
        @(posedge clk_i);
        #1;
        chk("rel_pending_before", 64'(pending_o), 64'd1);
        commit();
        push_frame(8);
        chk("rel_pending_after", 64'(pending_o), 64'd1);
        chk("rel_send_count", 64'(send_count_o), 64'(sc0 + 1));
        wait_drain(200, 1'b0, "rel");
        chk("rel_send_count_end", 64'(send_count_o), 64'(sc0 + 2));

        // Reset in the middle of a frame
        send_frame(64, 8'h33);
        repeat (8) tick();
        chk("mid_tvalid_before", 64'(tx_axis_tvalid_o), 64'd1);
        reset_i = 1'b1;
        tick();
        chk("mid_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        chk("mid_pending", 64'(pending_o), 64'd0);
        chk("mid_req", 64'(packet_req_o), 64'd1);
        chk("mid_send_count", 64'(send_count_o), 64'd0);
        exp_q.delete();
        reset_i = 1'b0;
        tick();
        send_frame(4, 8'h55);
        wait_drain(100, 1'b0, "post_rst");
        chk("post_rst_send_count", 64'(send_count_o), 64'd1);

        // 20-byte frame: padded to 60 bytes only when the feature is built in
        base = beats_seen;
        send_frame(20, 8'hA0);
        wait_drain(200, 1'b0, "f20");
`ifdef ETH_TX_PAD_EN
        chk("f20_beats", 64'(beats_seen - base), 64'd15);
`else
        chk("f20_beats", 64'(beats_seen - base), 64'd5);
`endif

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
